// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample per handshake, a single shared MAC walks all taps,
// and the result is held on a valid/ready output until the sink takes it.
module fir_mac_sequencer #(
  parameter int TAPS = 8,
  parameter int DW = 16,
  parameter int CW = 16,
  localparam int KW = $clog2(TAPS),
  localparam int AW = DW + CW + KW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we,
  input  logic [KW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          coef_busy,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic signed [CW-1:0]  r_coef [TAPS];
  logic signed [DW-1:0]  r_buf  [TAPS];
  logic [KW-1:0]         r_wr_ptr;
  logic [KW-1:0]         r_k;
  logic [AW-1:0]         r_acc;
  logic [AW-1:0]         r_out_data;

  logic                  w_accept;
  logic                  w_coef_wr;
  logic                  w_flush_now;
  logic                  w_mac_last;
  logic                  w_release;
  logic [KW-1:0]         w_rd_idx;
  logic signed [DW+CW-1:0] w_prod;
  logic [AW-1:0]         w_prod_ext;
  logic [AW-1:0]         w_acc_next;

  // Handshakes: a transfer happens on a rising edge where both valid and ready are
  // high; valid never depends on ready, and in_ready is only offered in IDLE without flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_coef_wr    = 1'b0;
    w_flush_now  = 1'b0;
    w_mac_last   = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_coef_wr = coef_we;
        if (flush) begin
          w_flush_now = 1'b1;
        end else if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_MAC;
        end
      end
      S_MAC: begin
        if (r_k == KW'(TAPS - 1)) begin
          w_mac_last   = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Tap k pairs with the sample k steps older than the newest one at wr_ptr.
  assign w_rd_idx   = r_wr_ptr - r_k;
  assign w_prod     = r_coef[r_k] * r_buf[w_rd_idx];
  assign w_prod_ext = {{KW{w_prod[DW+CW-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
        r_buf[i]  <= '0;
      end
      r_wr_ptr   <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      if (w_coef_wr) r_coef[coef_addr] <= coef_data;
      if (w_flush_now) begin
        for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
        r_wr_ptr <= '0;
      end else if (w_accept) begin
        r_buf[r_wr_ptr] <= in_data;
        r_acc           <= '0;
        r_k             <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= w_acc_next;
        r_k   <= r_k + 1'b1;
        if (w_mac_last) r_out_data <= w_acc_next;
      end
      if (w_release) r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  assign coef_busy = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_IDLE) && !flush;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  // dbg_state encoding: 0 = IDLE, 1 = MAC, 2 = DONE.
  assign dbg_state = r_state;

endmodule
